first_nios2_system_mem_tester: RTL and testbench

//  Avalon-MM master that drives the on-chip memory slave (s1/s2) from the initiator side.
//  On start it writes a deterministic pattern over a word range, reads it back and compares.
//  It reports pass/fail, the first failing address and a saturating error count.
//  It sits beside the Nios II data master and is used for bring-up and memory self-test.

---
 rtl/first_nios2_system_mem_tester.sv | 242 ++++++++++++++++++++++++
 tb/tb_first_nios2_system_mem_tester.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/first_nios2_system_mem_tester.sv
// first_nios2_system_mem_tester
//   Avalon-MM master for on-chip memory bring-up. On start it writes
//   data(i) = seed + i to addr(i) = base_addr + i (address wraps at 2^ADDR_W)
//   for i = 0 .. word_count-1, then reads every word back and compares.
//   Reports done, a sticky error flag, the first failing address and a
//   saturating mismatch count.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   start              one-cycle request, only honoured in IDLE
//   base_addr          first word address (latched on start)
//   word_count         number of words, 0 .. 2^ADDR_W (latched on start)
//   seed               pattern seed (latched on start)
//   busy, done         test running / test finished (level)
//   error, error_addr  sticky mismatch flag and address of the first mismatch
//   error_count        mismatch count, saturating at all-ones
//   avm_*              Avalon-MM master port towards the memory slave
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_WRITE | write strobe held on addr(i)/data(i) until accepted
// S_READ  | read strobe held on addr(i) until accepted
// S_WAIT  | read accepted, waiting out READ_LATENCY-1 cycles
// S_CHECK | readdata valid; compare against data(i)
// S_FIN   | one cycle before done rises
module first_nios2_system_mem_tester #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int ERRCNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_W-1:0]     error_addr,
  output logic [ERRCNT_W-1:0]   error_count,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  // WAIT is a down-counter: loading L-2 and leaving on zero gives L-1 cycles.
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT, S_CHECK, S_FIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W:0]       idx_q, idx_d, count_q, count_d;
  logic [ADDR_W-1:0]     base_q, base_d, addr_q, addr_d;
  logic [DATA_W-1:0]     seed_q, seed_d, data_q, data_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [ADDR_W-1:0]     error_addr_q, error_addr_d;
  logic [ERRCNT_W-1:0]   error_count_q, error_count_d;
  logic                  write_q, write_d, read_q, read_d;
  logic [ADDR_W-1:0]     address_q, address_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [ADDR_W:0]       idx_inc;
  logic                  last;

  assign idx_inc = idx_q + 1'b1;
  assign last    = (idx_inc == count_q);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    count_d       = count_q;
    base_d        = base_q;
    addr_d        = addr_q;
    seed_d        = seed_q;
    data_d        = data_q;
    lat_d         = lat_q;
    busy_d        = busy_q;
    done_d        = done_q;
    error_d       = error_q;
    error_addr_d  = error_addr_q;
    error_count_d = error_count_q;
    write_d       = 1'b0;
    read_d        = 1'b0;
    address_d     = '0;
    wdata_d       = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d       = word_count;
          base_d        = base_addr;
          seed_d        = seed;
          addr_d        = base_addr;
          data_d        = seed;
          idx_d         = '0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          error_d       = 1'b0;
          error_addr_d  = '0;
          error_count_d = '0;
          if (word_count == '0) begin
            state_d = S_FIN;
          end else begin
            state_d   = S_WRITE;
            write_d   = 1'b1;
            address_d = base_addr;
            wdata_d   = seed;
          end
        end
      end
      S_WRITE: begin
        write_d   = 1'b1;
        address_d = addr_q;
        wdata_d   = data_q;
        if (!avm_waitrequest) begin
          if (last) begin
            // Rewind the pattern generator for the read-back pass.
            idx_d     = '0;
            addr_d    = base_q;
            data_d    = seed_q;
            state_d   = S_READ;
            write_d   = 1'b0;
            wdata_d   = '0;
            read_d    = 1'b1;
            address_d = base_q;
          end else begin
            idx_d     = idx_inc;
            addr_d    = addr_q + 1'b1;
            data_d    = data_q + 1'b1;
            address_d = addr_q + 1'b1;
            wdata_d   = data_q + 1'b1;
          end
        end
      end
      S_READ: begin
        read_d    = 1'b1;
        address_d = addr_q;
        if (!avm_waitrequest) begin
          read_d    = 1'b0;
          address_d = '0;
          if (READ_LATENCY == 1) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_WAIT;
            lat_d   = LAT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (lat_q == '0) state_d = S_CHECK;
        else             lat_d   = lat_q - 1'b1;
      end
      S_CHECK: begin
        if (avm_readdata != data_q) begin
          if (error_count_q != {ERRCNT_W{1'b1}}) error_count_d = error_count_q + 1'b1;
          if (!error_q) begin
            error_d      = 1'b1;
            error_addr_d = addr_q;
          end
        end
        if (last) begin
          state_d = S_FIN;
        end else begin
          idx_d     = idx_inc;
          addr_d    = addr_q + 1'b1;
          data_d    = data_q + 1'b1;
          state_d   = S_READ;
          read_d    = 1'b1;
          address_d = addr_q + 1'b1;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      count_q       <= '0;
      base_q        <= '0;
      addr_q        <= '0;
      seed_q        <= '0;
      data_q        <= '0;
      lat_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      error_addr_q  <= '0;
      error_count_q <= '0;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      address_q     <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      count_q       <= count_d;
      base_q        <= base_d;
      addr_q        <= addr_d;
      seed_q        <= seed_d;
      data_q        <= data_d;
      lat_q         <= lat_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      error_addr_q  <= error_addr_d;
      error_count_q <= error_count_d;
      write_q       <= write_d;
      read_q        <= read_d;
      address_q     <= address_d;
      wdata_q       <= wdata_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign error_addr     = error_addr_q;
  assign error_count    = error_count_q;
  assign avm_write      = write_q;
  assign avm_read       = read_q;
  assign avm_address    = address_q;
  assign avm_writedata  = wdata_q;
  assign avm_chipselect = write_q | read_q;
  assign avm_byteenable = {BE_W{write_q | read_q}};

endmodule

// File: tb/tb_first_nios2_system_mem_tester.sv
module tb_first_nios2_system_mem_tester;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] base_addr = '0;
  logic [14:0] word_count = '0;
  logic [31:0] seed = '0;
  logic        busy, done, error;
  logic [13:0] error_addr;
  logic [15:0] error_count;
  logic [13:0] avm_address;
  logic        avm_chipselect, avm_write, avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;

  int tests = 0;
  int fails = 0;

  first_nios2_system_mem_tester dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy), .done(done),
    .error(error), .error_addr(error_addr), .error_count(error_count),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  // Slave model: on-chip RAM with read latency 1, optional readback corruption.
  logic [31:0] mem [0:16383];
  logic [13:0] wr_addr_log [0:63];
  logic [31:0] wr_data_log [0:63];
  logic [13:0] rd_addr_log [0:63];
  int          wr_n = 0;
  int          rd_n = 0;
  int          strobe_n = 0;
  logic        corrupt_en = 1'b0;
  logic [13:0] corrupt_lo = '0;
  logic [13:0] corrupt_hi = '0;

  always @(posedge clk) begin
    if (avm_write && !avm_waitrequest) begin
      mem[avm_address]       <= avm_writedata;
      wr_addr_log[wr_n % 64] <= avm_address;
      wr_data_log[wr_n % 64] <= avm_writedata;
      wr_n                   <= wr_n + 1;
    end
    if (avm_read && !avm_waitrequest) begin
      if (corrupt_en && avm_address >= corrupt_lo && avm_address <= corrupt_hi)
        avm_readdata <= 32'hDEADBEEF;
      else
        avm_readdata <= mem[avm_address];
      rd_addr_log[rd_n % 64] <= avm_address;
      rd_n                   <= rd_n + 1;
    end
    if (avm_read || avm_write || avm_chipselect || (avm_byteenable != 4'h0))
      strobe_n <= strobe_n + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Leaves the caller at the falling edge of the first cycle after start.
  task automatic pulse_start(input logic [13:0] b, input logic [14:0] n, input logic [31:0] s);
    @(negedge clk);
    base_addr  = b;
    word_count = n;
    seed       = s;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Counts cycles with the start cycle as 0; stops when done is seen.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) check({tag, " done timeout"}, 64'(done), 64'd1);
  endtask

  task automatic check_phase_logs(input string tag, input int wb, input int rb,
                                  input logic [13:0] b, input logic [31:0] s, input int n);
    logic [13:0] ea;
    logic [31:0] ed;
    check({tag, " write count"}, 64'(wr_n - wb), 64'(n));
    check({tag, " read count"},  64'(rd_n - rb), 64'(n));
    for (int k = 0; k < n; k++) begin
      ea = b + 14'(k);
      ed = s + 32'(k);
      check($sformatf("%s wr addr %0d", tag, k), 64'(wr_addr_log[(wb + k) % 64]), 64'(ea));
      check($sformatf("%s wr data %0d", tag, k), 64'(wr_data_log[(wb + k) % 64]), 64'(ed));
      check($sformatf("%s rd addr %0d", tag, k), 64'(rd_addr_log[(rb + k) % 64]), 64'(ea));
    end
  endtask

  initial begin
    int cyc, wb, rb, sb;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst error", 64'(error), 64'd0);
    check("rst strobes", 64'({avm_write, avm_read, avm_chipselect, avm_byteenable}), 64'd0);
    check("rst address", 64'(avm_address), 64'd0);
    check("rst errcnt", 64'(error_count), 64'd0);
    reset = 1'b0;

    // 1: clean run, base 0, four words
    wb = wr_n; rb = rd_n;
    pulse_start(14'h0000, 15'd4, 32'h1000_0000);
    check("t1 busy", 64'(busy), 64'd1);
    check("t1 first write", 64'({avm_write, avm_chipselect, avm_byteenable}), 64'h3F);
    wait_done("t1", cyc);
    check("t1 latency", 64'(cyc), 64'd14);
    check("t1 busy end", 64'(busy), 64'd0);
    check("t1 error", 64'(error), 64'd0);
    check("t1 errcnt", 64'(error_count), 64'd0);
    check_phase_logs("t1", wb, rb, 14'h0000, 32'h1000_0000, 4);

    // 2: single corrupted word at address 2
    corrupt_en = 1'b1; corrupt_lo = 14'd2; corrupt_hi = 14'd2;
    pulse_start(14'h0000, 15'd4, 32'h1000_0000);
    check("t2 done cleared", 64'(done), 64'd0);
    wait_done("t2", cyc);
    check("t2 error", 64'(error), 64'd1);
    check("t2 error_addr", 64'(error_addr), 64'd2);
    check("t2 errcnt", 64'(error_count), 64'd1);

    // 2b: three corrupted words; first failing address is kept
    corrupt_lo = 14'd1; corrupt_hi = 14'd3;
    pulse_start(14'h0000, 15'd4, 32'h1000_0000);
    wait_done("t2b", cyc);
    check("t2b error_addr", 64'(error_addr), 64'd1);
    check("t2b errcnt", 64'(error_count), 64'd3);
    corrupt_en = 1'b0;

    // 3: slave stalls the first write for three cycles
    wb = wr_n; rb = rd_n;
    avm_waitrequest = 1'b1;
    pulse_start(14'h0100, 15'd4, 32'hA5A5_0000);
    check("t3 error cleared", 64'(error), 64'd0);
    check("t3 errcnt cleared", 64'(error_count), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t3 stall write %0d", k), 64'(avm_write), 64'd1);
      check($sformatf("t3 stall addr %0d", k), 64'(avm_address), 64'h0100);
      check($sformatf("t3 stall data %0d", k), 64'(avm_writedata), 64'hA5A5_0000);
      if (k < 2) @(negedge clk);
    end
    check("t3 no write yet", 64'(wr_n - wb), 64'd0);
    avm_waitrequest = 1'b0;
    wait_done("t3", cyc);
    check("t3 error", 64'(error), 64'd0);
    check_phase_logs("t3", wb, rb, 14'h0100, 32'hA5A5_0000, 4);

    // 4: zero-length test
    sb = strobe_n;
    pulse_start(14'h0055, 15'd0, 32'h1234_5678);
    check("t4 busy", 64'(busy), 64'd1);
    wait_done("t4", cyc);
    check("t4 latency", 64'(cyc), 64'd2);
    @(negedge clk);
    check("t4 no strobes", 64'(strobe_n - sb), 64'd0);
    check("t4 error", 64'(error), 64'd0);

    // 5: address and data wrap
    wb = wr_n; rb = rd_n;
    pulse_start(14'h3FFE, 15'd4, 32'hFFFF_FFFE);
    wait_done("t5", cyc);
    check("t5 latency", 64'(cyc), 64'd14);
    check("t5 error", 64'(error), 64'd0);
    check_phase_logs("t5", wb, rb, 14'h3FFE, 32'hFFFF_FFFE, 4);

    // 6: reset in the middle of the write phase, then a clean rerun
    pulse_start(14'h0000, 15'd8, 32'h0BAD_0000);
    repeat (2) @(negedge clk);
    check("t6 writing", 64'(avm_write), 64'd1);
    reset = 1'b1;
    #1;
    check("t6 strobes dropped", 64'({avm_write, avm_read, avm_chipselect, avm_byteenable}), 64'd0);
    check("t6 addr/data zero", 64'({avm_address, avm_writedata}), 64'd0);
    check("t6 status zero", 64'({busy, done, error}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    wb = wr_n; rb = rd_n;
    pulse_start(14'h0020, 15'd4, 32'h1234_5678);
    wait_done("t6", cyc);
    check("t6 latency", 64'(cyc), 64'd14);
    check("t6 error", 64'(error), 64'd0);
    check("t6 errcnt", 64'(error_count), 64'd0);
    check_phase_logs("t6", wb, rb, 14'h0020, 32'h1234_5678, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
